// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: SPI slave pin bundle plus the TX/RX word handshake.
// Modports: slave (the endpoint itself) and master (whatever drives it).
interface spi_slave_port_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2:0]            i_data_config;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_tx_valid;
  logic                  o_tx_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_rx_valid;
  logic                  o_interrupt;
  logic                  o_tx_underrun;
  logic                  o_frame_err;
  logic                  i_SCK;
  logic                  i_SS;
  logic                  i_MOSI;
  logic                  o_MISO;
  logic                  o_MISO_oe;

  modport slave (
    input  i_data_config,
    input  i_data,
    input  i_tx_valid,
    output o_tx_ready,
    output o_data,
    output o_rx_valid,
    output o_interrupt,
    output o_tx_underrun,
    output o_frame_err,
    input  i_SCK,
    input  i_SS,
    input  i_MOSI,
    output o_MISO,
    output o_MISO_oe
  );

  modport master (
    output i_data_config,
    output i_data,
    output i_tx_valid,
    input  o_tx_ready,
    input  o_data,
    input  o_rx_valid,
    input  o_interrupt,
    input  o_tx_underrun,
    input  o_frame_err,
    output i_SCK,
    output i_SS,
    output i_MOSI,
    input  o_MISO,
    input  o_MISO_oe
  );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI slave, all logic on i_sys_clk.
// Ports: i_sys_clk, i_sys_rst (sync, high), bus (spi_slave_port_if.slave).
module spi_slave_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              i_sys_clk,
  input logic              i_sys_rst,
  spi_slave_port_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_d, ss_d;
  logic sck_s, ss_s, mosi_s;

  logic [2:0]    cfg, cfg_n;
  logic [W-1:0]  tx_shift, tx_n;
  logic [W-1:0]  rx_shift, rx_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [W-1:0]  hold, hold_n;
  logic          hold_full, full_n;
  logic          pend, pend_n;
  logic          first, first_n;
  logic [W-1:0]  data_q, data_n;
  logic          rv_q, rv_n;
  logic          ur_q, ur_n;
  logic          fe_q, fe_n;

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic lead, trail, sample, shift, lsb;
  logic load, wr;
  logic [W-1:0] rx_word;

  // SS flops reset low so a slave select already held low at reset
  // release does not look like a fresh falling edge.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.i_SCK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.i_SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_MOSI};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_rise  = ss_s & ~ss_d;
  assign ss_fall  = ~ss_s & ss_d;

  assign lead   = cfg[1] ? sck_fall : sck_rise;
  assign trail  = cfg[1] ? sck_rise : sck_fall;
  assign sample = cfg[0] ? trail : lead;
  assign shift  = cfg[0] ? lead : trail;
  assign lsb    = cfg[2];

  assign rx_word = lsb ? {mosi_s, rx_shift[W-1:1]}
                       : {rx_shift[W-2:0], mosi_s};

  assign wr = bus.i_tx_valid & ~hold_full;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state     <= IDLE;
      cfg       <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      pend      <= 1'b0;
      first     <= 1'b0;
      data_q    <= '0;
      rv_q      <= 1'b0;
      ur_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state     <= state_n;
      cfg       <= cfg_n;
      tx_shift  <= tx_n;
      rx_shift  <= rx_n;
      bit_cnt   <= cnt_n;
      hold      <= hold_n;
      hold_full <= full_n;
      pend      <= pend_n;
      first     <= first_n;
      data_q    <= data_n;
      rv_q      <= rv_n;
      ur_q      <= ur_n;
      fe_q      <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cfg_n   = cfg;
    tx_n    = tx_shift;
    rx_n    = rx_shift;
    cnt_n   = bit_cnt;
    hold_n  = hold;
    full_n  = hold_full;
    pend_n  = pend;
    first_n = first;
    data_n  = data_q;
    rv_n    = 1'b0;
    ur_n    = 1'b0;
    fe_n    = 1'b0;
    load    = 1'b0;

    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = SHIFT;
          cfg_n   = bus.i_data_config;
          load    = 1'b1;
          cnt_n   = '0;
          rx_n    = '0;
          pend_n  = 1'b0;
          first_n = 1'b1;
        end
      end
      SHIFT: begin
        if (sample) begin
          rx_n = rx_word;
          if (bit_cnt == CW'(W - 1)) begin
            data_n = rx_word;
            rv_n   = 1'b1;
            cnt_n  = '0;
            pend_n = 1'b1;
          end else begin
            cnt_n = bit_cnt + CW'(1);
          end
        end else if (shift && !ss_rise) begin
          first_n = 1'b0;
          if (pend) begin
            load   = 1'b1;
            pend_n = 1'b0;
          end else if (!(first && cfg[0])) begin
            // CPHA=1: bit 0 is already on MISO from the load,
            // so the first shift edge only consumes the slot.
            tx_n = lsb ? (tx_shift >> 1) : (tx_shift << 1);
          end
        end
        // A sample landing with SS rise completes the frame first.
        if (ss_rise) begin
          state_n = IDLE;
          pend_n  = 1'b0;
          fe_n    = (cnt_n != '0);
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      tx_n = hold_full ? hold : '0;
      ur_n = ~hold_full;
    end

    // A write alongside a load lands in the freshly emptied holding reg.
    if (load) begin
      full_n = wr;
      if (wr) hold_n = bus.i_data;
    end else if (wr) begin
      full_n = 1'b1;
      hold_n = bus.i_data;
    end
  end

  assign bus.o_tx_ready    = ~hold_full;
  assign bus.o_data        = data_q;
  assign bus.o_rx_valid    = rv_q;
  assign bus.o_interrupt   = rv_q;
  assign bus.o_tx_underrun = ur_q;
  assign bus.o_frame_err   = fe_q;
  assign bus.o_MISO_oe     = (state == SHIFT);
  assign bus.o_MISO        = (state == SHIFT) &
                             (lsb ? tx_shift[0] : tx_shift[W-1]);

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: SPI master model plus RX scoreboard.
// Drives spi_slave_port through its interface.
module tb_spi_slave_port;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_port_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_port #(
    .DATA_WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_rv = 0, n_irq = 0, n_ur = 0, n_fe = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (bus.o_interrupt)   n_irq++;
    if (bus.o_tx_underrun) n_ur++;
    if (bus.o_frame_err)   n_fe++;
    if (bus.o_rx_valid) begin
      n_rv++;
      checks++;
      if (exp_rx.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected got=%h exp=none", bus.o_data);
      end else begin
        mon_exp = exp_rx.pop_front();
        if (bus.o_data !== mon_exp) begin
          failures++;
          $display("FAIL rx_data got=%h exp=%h", bus.o_data, mon_exp);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    bus.i_data     = d;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
  endtask

  // Master model: up to two frames in one SS-low burst.
  task automatic xfer(
    input  logic [2:0] cfg,
    input  logic [7:0] t0,
    input  logic [7:0] t1,
    input  int         nbits,
    input  bit         keep_low,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic       rdy0
  );
    logic [7:0] tf [2];
    logic [7:0] rf [2];
    logic cpha, cpol, lsb;
    int f, k, p;
    cpha = cfg[0];
    cpol = cfg[1];
    lsb  = cfg[2];
    tf[0] = t0;
    tf[1] = t1;
    rf[0] = '0;
    rf[1] = '0;
    rdy0  = 1'b0;
    bus.i_data_config = cfg;
    bus.i_SCK = cpol;
    wait_cyc(HALF);
    bus.i_SS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      f = i / 8;
      k = i % 8;
      p = lsb ? k : 7 - k;
      if (!cpha) begin
        bus.i_MOSI = tf[f][p];
        wait_cyc(HALF);
        if (i == 0) rdy0 = bus.o_tx_ready;
        bus.i_SCK = ~cpol;
        rf[f][p] = bus.o_MISO;
        wait_cyc(HALF);
        bus.i_SCK = cpol;
      end else begin
        wait_cyc(HALF);
        if (i == 0) rdy0 = bus.o_tx_ready;
        bus.i_SCK  = ~cpol;
        bus.i_MOSI = tf[f][p];
        wait_cyc(HALF);
        bus.i_SCK = cpol;
        rf[f][p] = bus.o_MISO;
      end
    end
    wait_cyc(HALF);
    if (!keep_low) bus.i_SS = 1'b1;
    wait_cyc(2 * HALF);
    r0 = rf[0];
    r1 = rf[1];
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.o_tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_tx_ready got=%b exp=1", bus.o_tx_ready);
    end
    checks++;
    if (bus.o_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data got=%h exp=00", bus.o_data);
    end
    checks++;
    if ({bus.o_rx_valid, bus.o_interrupt} !== 2'b00) begin
      failures++;
      $display("FAIL rst_rx_pulses got=%b%b exp=00",
               bus.o_rx_valid, bus.o_interrupt);
    end
    checks++;
    if ({bus.o_tx_underrun, bus.o_frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL rst_err_pulses got=%b%b exp=00",
               bus.o_tx_underrun, bus.o_frame_err);
    end
    checks++;
    if ({bus.o_MISO, bus.o_MISO_oe} !== 2'b00) begin
      failures++;
      $display("FAIL rst_miso got=%b%b exp=00",
               bus.o_MISO, bus.o_MISO_oe);
    end
  endtask

  task automatic test_mode0_msb();
    logic [7:0] r0, r1;
    logic rdy;
    int rv0, irq0;
    tx_write(8'h3C);
    rv0  = n_rv;
    irq0 = n_irq;
    exp_rx.push_back(8'hA5);
    xfer(3'b000, 8'hA5, 8'h00, 8, 1'b0, r0, r1, rdy);
    checks++;
    if (r0 !== 8'h3C) begin
      failures++;
      $display("FAIL m0_miso got=%h exp=3c", r0);
    end
    checks++;
    if (n_rv - rv0 !== 1) begin
      failures++;
      $display("FAIL m0_rv_count got=%0d exp=1", n_rv - rv0);
    end
    checks++;
    if (n_irq - irq0 !== 1) begin
      failures++;
      $display("FAIL m0_irq_count got=%0d exp=1", n_irq - irq0);
    end
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] r0, r1;
    logic rdy;
    tx_write(8'h81);
    checks++;
    if (bus.o_tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL m3_ready_full got=%b exp=0", bus.o_tx_ready);
    end
    exp_rx.push_back(8'h4E);
    xfer(3'b111, 8'h4E, 8'h00, 8, 1'b0, r0, r1, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL m3_ready_at_ss got=%b exp=1", rdy);
    end
    checks++;
    if (r0 !== 8'h81) begin
      failures++;
      $display("FAIL m3_miso got=%h exp=81", r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1;
    logic rdy;
    bit wrote;
    int ur0;
    tx_write(8'h11);
    ur0   = n_ur;
    wrote = 1'b0;
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    fork
      xfer(3'b001, 8'hF0, 8'h0F, 16, 1'b0, r0, r1, rdy);
      begin
        for (int k = 0; k < 200 && !wrote; k++) begin
          @(negedge clk);
          if (bus.o_tx_ready) begin
            bus.i_data     = 8'h22;
            bus.i_tx_valid = 1'b1;
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
            wrote = 1'b1;
          end
        end
      end
    join
    checks++;
    if (wrote !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_timeout got=%b exp=1", wrote);
    end
    checks++;
    if (r0 !== 8'h11) begin
      failures++;
      $display("FAIL b2b_miso0 got=%h exp=11", r0);
    end
    checks++;
    if (r1 !== 8'h22) begin
      failures++;
      $display("FAIL b2b_miso1 got=%h exp=22", r1);
    end
    checks++;
    if (n_ur - ur0 !== 0) begin
      failures++;
      $display("FAIL b2b_underrun got=%0d exp=0", n_ur - ur0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] r0, r1;
    logic rdy;
    int ur0;
    ur0 = n_ur;
    exp_rx.push_back(8'h55);
    xfer(3'b001, 8'h55, 8'h00, 8, 1'b0, r0, r1, rdy);
    checks++;
    if (n_ur - ur0 !== 1) begin
      failures++;
      $display("FAIL ur_count got=%0d exp=1", n_ur - ur0);
    end
    checks++;
    if (r0 !== 8'h00) begin
      failures++;
      $display("FAIL ur_miso got=%h exp=00", r0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] r0, r1;
    logic rdy;
    int rv0, fe0;
    rv0 = n_rv;
    fe0 = n_fe;
    xfer(3'b000, 8'hE0, 8'h00, 3, 1'b0, r0, r1, rdy);
    checks++;
    if (n_fe - fe0 !== 1) begin
      failures++;
      $display("FAIL abort_fe got=%0d exp=1", n_fe - fe0);
    end
    checks++;
    if (n_rv - rv0 !== 0) begin
      failures++;
      $display("FAIL abort_rv got=%0d exp=0", n_rv - rv0);
    end
    exp_rx.push_back(8'hC3);
    fe0 = n_fe;
    xfer(3'b000, 8'hC3, 8'h00, 8, 1'b0, r0, r1, rdy);
    checks++;
    if (n_fe - fe0 !== 0) begin
      failures++;
      $display("FAIL abort_next_fe got=%0d exp=0", n_fe - fe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r0, r1;
    logic rdy;
    int rv0, fe0, oe_seen;
    tx_write(8'h5A);
    rv0 = n_rv;
    fe0 = n_fe;
    xfer(3'b000, 8'hFF, 8'h00, 4, 1'b1, r0, r1, rdy);
    checks++;
    if (bus.o_MISO_oe !== 1'b1) begin
      failures++;
      $display("FAIL rm_oe_active got=%b exp=1", bus.o_MISO_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_tx_ready, bus.o_data, bus.o_MISO, bus.o_MISO_oe}
        !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rm_outputs got=%b_%h_%b%b exp=1_00_00",
               bus.o_tx_ready, bus.o_data, bus.o_MISO, bus.o_MISO_oe);
    end
    wait_cyc(2);
    rst = 1'b0;
    oe_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.o_MISO_oe) oe_seen++;
    end
    checks++;
    if (oe_seen !== 0) begin
      failures++;
      $display("FAIL rm_stay_idle got=%0d exp=0", oe_seen);
    end
    checks++;
    if ({n_rv - rv0, n_fe - fe0} !== {32'd0, 32'd0}) begin
      failures++;
      $display("FAIL rm_pulses got=%0d,%0d exp=0,0",
               n_rv - rv0, n_fe - fe0);
    end
    bus.i_SS = 1'b1;
    wait_cyc(2 * HALF);
    tx_write(8'h3C);
    exp_rx.push_back(8'h96);
    xfer(3'b001, 8'h96, 8'h00, 8, 1'b0, r0, r1, rdy);
    checks++;
    if (r0 !== 8'h3C) begin
      failures++;
      $display("FAIL rm_next_miso got=%h exp=3c", r0);
    end
  endtask

  initial begin
    bus.i_data_config = 3'b000;
    bus.i_data        = '0;
    bus.i_tx_valid    = 1'b0;
    bus.i_SCK         = 1'b0;
    bus.i_SS          = 1'b1;
    bus.i_MOSI        = 1'b0;
    test_reset();
    test_mode0_msb();
    test_mode3_lsb();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    wait_cyc(4);
    checks++;
    if (exp_rx.size() !== 0) begin
      failures++;
      $display("FAIL rx_missing got=%0d exp=0", exp_rx.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

SPI slave endpoint that answers the design's SPI master over the SCK/SS/MOSI/MISO pins. The block is clocked entirely by the system clock. It oversamples the incoming SCK, SS and MOSI through synchronizers and shifts a frame in from MOSI while shifting a frame out on MISO. Mode (CPOL/CPHA) and bit order match the master's data configuration, so the block can sit opposite the master on the same bus as the loop-back responder.

## Interface
- DATA_WIDTH, 8, frame length in bits (≥2)
- SYNC_STAGES, 2, flop stages on each pin input (≥2)

Clocking: one clock; reset is synchronous and active-high.

- i_sys_clk  in  1  system clock, single clock domain
- i_sys_rst  in  1  synchronous, active-high reset
- i_data_config  in  3  [0] CPHA, [1] CPOL, [2] 1 = LSB-first; latched at each SS assertion
- i_data  in  DATA_WIDTH  TX word for the next frame
- i_tx_valid  in  1  i_data valid; accepted when i_tx_valid & o_tx_ready
- o_tx_ready  out  1  TX holding register empty
- o_data  out  DATA_WIDTH  last received frame
- o_rx_valid  out  1  one-cycle pulse, o_data updated
- o_interrupt  out  1  one-cycle pulse on frame completion (same cycle as o_rx_valid)
- o_tx_underrun  out  1  one-cycle pulse, frame started with holding register empty
- o_frame_err  out  1  one-cycle pulse, SS deasserted mid-frame
- i_SCK  in  1  serial clock from master
- i_SS  in  1  slave select, active low
- i_MOSI  in  1  master data in
- o_MISO  out  1  slave data out
- o_MISO_oe  out  1  MISO output enable (tri-state control)

## Operation
- Synchronize i_SCK, i_SS and i_MOSI through SYNC_STAGES flops, then add one extra flop on SCK and SS for edge detection.
- Edge classes:
  - Leading edge = SCK leaves its CPOL idle level. Trailing edge = SCK returns to it.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- FSM IDLE / SHIFT:
  - IDLE → SHIFT on synced SS falling edge. On that transition:
    - latch i_data_config;
    - load tx_shift from the holding register, or 0 with an o_tx_underrun pulse if it is empty;
    - mark holding empty;
    - clear bit_cnt.
  - SHIFT → IDLE on synced SS rising edge. If 0 < bit_cnt < DATA_WIDTH, pulse o_frame_err and discard the partial frame (no o_rx_valid).
- Sample edge in SHIFT:
  - MSB-first: rx_shift <= {rx_shift[W-2:0], mosi}. LSB-first: rx_shift <= {mosi, rx_shift[W-1:1]}.
  - bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH: o_data <= assembled word; pulse o_rx_valid and o_interrupt; bit_cnt <= 0; frame reload is pending.
- Shift edge in SHIFT:
  - Reload pending: load tx_shift from holding, or 0 with o_tx_underrun if empty; clear pending.
  - Otherwise shift tx_shift toward the output bit, except on the first shift edge of a frame with CPHA=1. The first bit is already presented at load, so that edge only consumes a slot.
- o_MISO = tx_shift[W-1] (MSB-first) or tx_shift[0] (LSB-first). o_MISO_oe = 1 only in SHIFT; o_MISO = 0 when not enabled.
- Holding register:
  - o_tx_ready = holding empty.
  - A write while not ready is ignored. A write in the same cycle as a load is not lost: the load takes the old contents and the new word lands in holding.
- Back-to-back frames with SS held low are supported with no gap.

## Timing
- Reset values: o_tx_ready=1, o_data=0, o_rx_valid=0, o_interrupt=0, o_tx_underrun=0, o_frame_err=0, o_MISO=0, o_MISO_oe=0. State is IDLE and all shift registers and counters are 0.
- Pin-to-action latency is SYNC_STAGES+1 i_sys_clk cycles from an SCK/SS pin edge to the internal edge pulse. o_rx_valid asserts 1 cycle after the internal sample-edge pulse of the last bit.
- SCK half-period must be ≥ SYNC_STAGES+3 i_sys_clk cycles (SCK ≤ i_sys_clk/10 at defaults).
- SS falling to first SCK edge must be ≥ SYNC_STAGES+3 cycles, so MISO bit 0 is stable before the first sample.
- Synchronous reset mid-frame: all outputs return to reset values on the next edge, and no pulses are emitted. SS held low after reset release stays IDLE until a fresh SS falling edge.
- SS deassert and a final sample edge in the same cycle: the sample completes the frame first (o_rx_valid), so no o_frame_err.

## Test plan
- Mode 0, MSB-first: load 0x3C, master sends 0xA5 → o_data=0xA5 with one o_rx_valid/o_interrupt pulse; master receives 0x3C.
- Mode 3, LSB-first: load 0x81, master sends 0x4E → o_data=0x4E; master receives 0x81; o_tx_ready rises at SS assertion.
- Back-to-back: preload 0x11, then write 0x22 after the first load; one SS-low burst of 16 clocks with MOSI 0xF0,0x0F → o_data 0xF0 then 0x0F; MISO 0x11 then 0x22; no underrun.
- Underrun: no TX write, frame with MOSI 0x55 → o_tx_underrun pulse, MISO all 0, o_data=0x55.
- Abort: SS raised after 3 bits → o_frame_err pulse, o_rx_valid stays 0; next full frame 0xC3 is received correctly.
- Reset mid-frame after 4 bits → outputs at reset values; o_MISO_oe=0 until the next SS falling edge.
